mux2_stream_arbiter: RTL

- Shares one WIDTH-bit output channel between two packet-based valid/ready requesters (i0, i1) by driving the select of a 2:1 datapath mux.
- Grants are round-robin and locked per packet: a grant is held until the beat carrying last is accepted.
- Output is registered, giving one pipeline stage with full throughput. It sits between two producers and a single shared downstream consumer.

---
 rtl/mux2_arb_pkg.sv | 18 +
 rtl/mux2_w.sv | 19 +
 rtl/mux2_stream_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mux2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux2_arb_pkg
// Purpose  : Shared state encoding and defaults for the two-way stream arbiter.
// Revision : 1.0
// ============================================================================
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_t;

    localparam int ARB_WIDTH_DEF = 8;

endpackage : mux2_arb_pkg
`default_nettype wire

// File: rtl/mux2_w.sv
`default_nettype none
// ============================================================================
// Module   : mux2_w
// Purpose  : W-bit 2:1 multiplexer (i_sel = 0 selects i_a).
// Revision : 1.0
// ============================================================================
module mux2_w #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sel,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule : mux2_w
`default_nettype wire

// File: rtl/mux2_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_stream_arbiter
// Purpose  : Packet-locked round-robin arbiter sharing one registered
//            valid/ready output channel between two requesters.
// Revision : 1.0
// ============================================================================
import mux2_arb_pkg::*;

module mux2_stream_arbiter #(
    parameter int WIDTH = ARB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    input  logic             i0_last,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    input  logic             i1_last,
    output logic             i1_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last_gnt;
    logic             w_last_gnt_nxt;
    logic             r_sel;
    logic [WIDTH-1:0] r_y_data;
    logic             r_y_last;
    logic             r_y_valid;

    logic             w_can_load;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer;
    logic             w_rel;
    logic [WIDTH:0]   w_mux;

    assign w_can_load = !r_y_valid || y_ready;
    assign i0_ready   = (r_state == ARB_GNT0) && w_can_load;
    assign i1_ready   = (r_state == ARB_GNT1) && w_can_load;
    assign w_xfer0    = i0_valid && i0_ready;
    assign w_xfer1    = i1_valid && i1_ready;
    assign w_xfer     = w_xfer0 || w_xfer1;

    // sel already tracks the owner whenever a transfer can happen
    mux2_w #(
        .W (WIDTH + 1)
    ) u_mux (
        .i_a   ({i0_last, i0_data}),
        .i_b   ({i1_last, i1_data}),
        .i_sel (r_sel),
        .o_y   (w_mux)
    );

    assign w_rel = w_xfer && w_mux[WIDTH];

    always_comb begin
        w_state_nxt    = r_state;
        w_last_gnt_nxt = r_last_gnt;
        case (r_state)
            ARB_IDLE: begin
                if (i0_valid && i1_valid) begin
                    w_state_nxt = r_last_gnt ? ARB_GNT0 : ARB_GNT1;
                end else if (i0_valid) begin
                    w_state_nxt = ARB_GNT0;
                end else if (i1_valid) begin
                    w_state_nxt = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (w_rel) begin
                    w_last_gnt_nxt = 1'b0;
                    if (i1_valid)      w_state_nxt = ARB_GNT1;
                    else if (i0_valid) w_state_nxt = ARB_GNT0;
                    else               w_state_nxt = ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (w_rel) begin
                    w_last_gnt_nxt = 1'b1;
                    if (i0_valid)      w_state_nxt = ARB_GNT0;
                    else if (i1_valid) w_state_nxt = ARB_GNT1;
                    else               w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= 1'b1;
            r_sel      <= 1'b0;
            r_y_data   <= '0;
            r_y_last   <= 1'b0;
            r_y_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            // IDLE keeps the previous select
            if (w_state_nxt == ARB_GNT0) begin
                r_sel <= 1'b0;
            end else if (w_state_nxt == ARB_GNT1) begin
                r_sel <= 1'b1;
            end
            if (w_xfer) begin
                r_y_data  <= w_mux[WIDTH-1:0];
                r_y_last  <= w_mux[WIDTH];
                r_y_valid <= 1'b1;
            end else if (y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y_data  = r_y_data;
    assign y_last  = r_y_last;
    assign y_valid = r_y_valid;
    assign sel     = r_sel;
    assign busy    = (r_state != ARB_IDLE);

endmodule : mux2_stream_arbiter
`default_nettype wire
